// File: rtl/spu_pkg.sv
// Shared types for the SPU dual-issue scoreboard.
// Slot bundle, FSM states and latency helper.
package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int ADDR_W   = 7;
    localparam int LAT_W    = 3;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [LAT_W-1:0]  lat_t;

    typedef enum logic {
        PAIR,
        SECOND
    } issue_state_e;

    typedef enum logic {
        EVEN,
        ODD
    } pipe_e;

    typedef struct packed {
        logic      valid;
        reg_addr_t ra;
        reg_addr_t rb;
        reg_addr_t rc;
        logic [2:0] src_use;
        reg_addr_t rt;
        logic      wr;
        lat_t      lat;
        pipe_e     pipe;
    } slot_t;

    // A zero latency still occupies the register for one cycle.
    function automatic lat_t eff_lat(input lat_t lat);
        return (lat == '0) ? lat_t'(1) : lat;
    endfunction

endpackage

// File: rtl/spu_sb_hazard.sv
// Per-slot RAW/WAW check against the latency scoreboard.
// Purely combinational; one copy per issue slot.
module spu_sb_hazard
    import spu_pkg::*;
(
    input  slot_t slot,
    input  lat_t  cnt [NUM_REGS],
    output logic  raw,
    output logic  waw
);

    logic ra_busy;
    logic rb_busy;
    logic rc_busy;
    logic unused_pipe;

    assign ra_busy = slot.src_use[0] & (cnt[slot.ra] != '0);
    assign rb_busy = slot.src_use[1] & (cnt[slot.rb] != '0);
    assign rc_busy = slot.src_use[2] & (cnt[slot.rc] != '0);

    assign raw = slot.valid & (ra_busy | rb_busy | rc_busy);
    assign waw = slot.valid & slot.wr
               & (cnt[slot.rt] > eff_lat(slot.lat));

    assign unused_pipe = slot.pipe;

endmodule

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard/issue control for the SPU ID stage.
// Latency scoreboard, even/odd pairing FSM and stall counter.
module spu_issue_scoreboard
    import spu_pkg::*;
#(
    parameter int NUM_REGS = spu_pkg::NUM_REGS,
    parameter int ADDR_W   = spu_pkg::ADDR_W,
    parameter int LAT_W    = spu_pkg::LAT_W,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              i1_valid,
    input  logic [ADDR_W-1:0] i1_ra,
    input  logic [ADDR_W-1:0] i1_rb,
    input  logic [ADDR_W-1:0] i1_rc,
    input  logic [2:0]        i1_use,
    input  logic [ADDR_W-1:0] i1_rt,
    input  logic              i1_wr,
    input  logic [LAT_W-1:0]  i1_lat,
    input  logic              i1_pipe,
    input  logic              i2_valid,
    input  logic [ADDR_W-1:0] i2_ra,
    input  logic [ADDR_W-1:0] i2_rb,
    input  logic [ADDR_W-1:0] i2_rc,
    input  logic [2:0]        i2_use,
    input  logic [ADDR_W-1:0] i2_rt,
    input  logic              i2_wr,
    input  logic [LAT_W-1:0]  i2_lat,
    input  logic              i2_pipe,
    output logic              issue1,
    output logic              issue2,
    output logic              PC_enable,
    output logic [CNT_W-1:0]  stall_cycles
);

    slot_t        s1;
    slot_t        s2;
    lat_t         cnt_q [NUM_REGS];
    issue_state_e state_q;
    issue_state_e state_d;
    logic [CNT_W-1:0] stall_q;

    logic raw1;
    logic waw1;
    logic raw2;
    logic waw2;
    logic ok1;
    logic ok2;
    logic raw_pair;
    logic waw_pair;
    logic struct_h;
    logic pair_bad;
    logic ld1;
    logic ld2;
    lat_t lat1;
    lat_t lat2;

    assign s1 = '{valid: i1_valid, ra: i1_ra, rb: i1_rb,
                  rc: i1_rc, src_use: i1_use, rt: i1_rt,
                  wr: i1_wr, lat: i1_lat,
                  pipe: pipe_e'(i1_pipe)};
    assign s2 = '{valid: i2_valid, ra: i2_ra, rb: i2_rb,
                  rc: i2_rc, src_use: i2_use, rt: i2_rt,
                  wr: i2_wr, lat: i2_lat,
                  pipe: pipe_e'(i2_pipe)};

    spu_sb_hazard u_hz1 (
        .slot (s1),
        .cnt  (cnt_q),
        .raw  (raw1),
        .waw  (waw1)
    );

    spu_sb_hazard u_hz2 (
        .slot (s2),
        .cnt  (cnt_q),
        .raw  (raw2),
        .waw  (waw2)
    );

    assign ok1 = i1_valid & ~raw1 & ~waw1;
    assign ok2 = i2_valid & ~raw2 & ~waw2;

    // Slot 1 result is not yet on the scoreboard when both sit in ID.
    assign raw_pair = s1.wr & (
          (s2.src_use[0] & (s2.ra == s1.rt))
        | (s2.src_use[1] & (s2.rb == s1.rt))
        | (s2.src_use[2] & (s2.rc == s1.rt)));
    assign waw_pair = s1.wr & s2.wr & (s1.rt == s2.rt);
    assign struct_h = (s1.pipe == s2.pipe);
    assign pair_bad = raw_pair | waw_pair | struct_h;

    always_comb begin
        issue1    = 1'b0;
        issue2    = 1'b0;
        PC_enable = 1'b0;
        state_d   = state_q;
        if (reset) begin
            state_d = PAIR;
        end else if (flush) begin
            PC_enable = 1'b1;
            state_d   = PAIR;
        end else begin
            unique case (state_q)
                PAIR: begin
                    issue1 = ok1;
                    if (i1_valid) begin
                        issue2 = ok1 & ok2 & ~pair_bad;
                    end else begin
                        issue2 = ok2;
                    end
                    PC_enable = (~i1_valid | issue1)
                              & (~i2_valid | issue2);
                    if (issue1 & i2_valid & ~issue2) begin
                        state_d = SECOND;
                    end
                end
                SECOND: begin
                    issue2 = ok2;
                    if (issue2) begin
                        PC_enable = 1'b1;
                        state_d   = PAIR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PAIR;
        end else begin
            state_q <= state_d;
        end
    end

    assign ld1  = issue1 & i1_wr;
    assign ld2  = issue2 & i2_wr;
    assign lat1 = eff_lat(s1.lat);
    assign lat2 = eff_lat(s2.lat);

    // Squashed writers stay on the board; they only cost extra wait.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset) begin
                cnt_q[r] <= '0;
            end else if (ld1 && s1.rt == reg_addr_t'(r)) begin
                cnt_q[r] <= lat1;
            end else if (ld2 && s2.rt == reg_addr_t'(r)) begin
                cnt_q[r] <= lat2;
            end else if (cnt_q[r] != '0) begin
                cnt_q[r] <= cnt_q[r] - lat_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!PC_enable && !(&stall_q)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed bench for spu_issue_scoreboard.
// Hand-computed expectations per cycle.
module tb_spu_issue_scoreboard;
    import spu_pkg::*;

    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          i1_valid;
    logic [6:0]    i1_ra;
    logic [6:0]    i1_rb;
    logic [6:0]    i1_rc;
    logic [2:0]    i1_use;
    logic [6:0]    i1_rt;
    logic          i1_wr;
    logic [2:0]    i1_lat;
    logic          i1_pipe;
    logic          i2_valid;
    logic [6:0]    i2_ra;
    logic [6:0]    i2_rb;
    logic [6:0]    i2_rc;
    logic [2:0]    i2_use;
    logic [6:0]    i2_rt;
    logic          i2_wr;
    logic [2:0]    i2_lat;
    logic          i2_pipe;
    logic          issue1;
    logic          issue2;
    logic          PC_enable;
    logic [CW-1:0] stall_cycles;

    int n_cmp;
    int n_bad;

    spu_issue_scoreboard #(.CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .i1_valid     (i1_valid),
        .i1_ra        (i1_ra),
        .i1_rb        (i1_rb),
        .i1_rc        (i1_rc),
        .i1_use       (i1_use),
        .i1_rt        (i1_rt),
        .i1_wr        (i1_wr),
        .i1_lat       (i1_lat),
        .i1_pipe      (i1_pipe),
        .i2_valid     (i2_valid),
        .i2_ra        (i2_ra),
        .i2_rb        (i2_rb),
        .i2_rc        (i2_rc),
        .i2_use       (i2_use),
        .i2_rt        (i2_rt),
        .i2_wr        (i2_wr),
        .i2_lat       (i2_lat),
        .i2_pipe      (i2_pipe),
        .issue1       (issue1),
        .issue2       (issue2),
        .PC_enable    (PC_enable),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic v, input logic [6:0] ra,
                        input logic [6:0] rb, input logic [6:0] rc,
                        input logic [2:0] u, input logic [6:0] rt,
                        input logic wr, input logic [2:0] lat,
                        input logic p);
        i1_valid = v;  i1_ra = ra;  i1_rb = rb;  i1_rc = rc;
        i1_use = u;  i1_rt = rt;  i1_wr = wr;  i1_lat = lat;
        i1_pipe = p;
    endtask

    task automatic drv2(input logic v, input logic [6:0] ra,
                        input logic [6:0] rb, input logic [6:0] rc,
                        input logic [2:0] u, input logic [6:0] rt,
                        input logic wr, input logic [2:0] lat,
                        input logic p);
        i2_valid = v;  i2_ra = ra;  i2_rb = rb;  i2_rc = rc;
        i2_use = u;  i2_rt = rt;  i2_wr = wr;  i2_lat = lat;
        i2_pipe = p;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        flush = 1'b0;
        drv1(1, 0, 0, 0, 3'b000, 5, 1, 2, 0);
        drv2(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);

        // 1: reset, then ILW r5 lat 2
        nxt(); #1;
        chk("rst_issue1", issue1, 0);
        chk("rst_pc", PC_enable, 0);
        chk("rst_stall", stall_cycles, 0);
        nxt(); reset = 1'b0; #1;
        chk("t1_issue1", issue1, 1);
        chk("t1_pc", PC_enable, 1);

        // 2: RAW on r5 stalls two cycles
        nxt(); drv1(1, 5, 0, 0, 3'b001, 0, 0, 1, 0); #1;
        chk("t1_cnt5", dut.cnt_q[5], 2);
        chk("t2_issue1_a", issue1, 0);
        chk("t2_pc_a", PC_enable, 0);
        nxt(); #1;
        chk("t2_issue1_b", issue1, 0);
        chk("t2_pc_b", PC_enable, 0);
        nxt(); #1;
        chk("t2_issue1_c", issue1, 1);
        chk("t2_pc_c", PC_enable, 1);
        chk("t2_stall", stall_cycles, 2);

        // 3: pair RAW on r9, lat 3
        nxt();
        drv1(1, 0, 0, 0, 3'b000, 9, 1, 3, 0);
        drv2(1, 0, 9, 0, 3'b010, 0, 0, 1, 1);
        #1;
        chk("t3_issue1", issue1, 1);
        chk("t3_issue2", issue2, 0);
        chk("t3_pc", PC_enable, 0);
        nxt(); #1;
        chk("t3_state", dut.state_q, SECOND);
        chk("t3_cnt9", dut.cnt_q[9], 3);
        chk("t3_issue1_s", issue1, 0);
        chk("t3_issue2_a", issue2, 0);
        nxt(); #1;
        chk("t3_issue2_b", issue2, 0);
        nxt(); #1;
        chk("t3_issue2_c", issue2, 0);
        nxt(); #1;
        chk("t3_issue2_d", issue2, 1);
        chk("t3_pc_d", PC_enable, 1);
        chk("t3_stall", stall_cycles, 6);

        // 4: both on odd pipe
        nxt();
        drv1(1, 0, 0, 0, 3'b000, 10, 1, 1, 1);
        drv2(1, 0, 0, 0, 3'b000, 11, 1, 1, 1);
        #1;
        chk("t4_issue1", issue1, 1);
        chk("t4_issue2_a", issue2, 0);
        chk("t4_pc_a", PC_enable, 0);
        nxt(); #1;
        chk("t4_issue1_b", issue1, 0);
        chk("t4_issue2_b", issue2, 1);
        chk("t4_pc_b", PC_enable, 1);
        chk("t4_stall", stall_cycles, 7);

        // 5: flush while SECOND is blocked
        nxt();
        drv1(1, 0, 0, 0, 3'b000, 20, 1, 7, 0);
        drv2(1, 20, 0, 0, 3'b001, 0, 0, 1, 1);
        #1;
        chk("t5_issue1", issue1, 1);
        chk("t5_issue2", issue2, 0);
        nxt(); #1;
        chk("t5_state_s", dut.state_q, SECOND);
        chk("t5_pc_s", PC_enable, 0);
        nxt(); flush = 1'b1; #1;
        chk("t5_fl_issue1", issue1, 0);
        chk("t5_fl_issue2", issue2, 0);
        chk("t5_fl_pc", PC_enable, 1);
        chk("t5_fl_cnt20", dut.cnt_q[20], 6);
        nxt();
        flush = 1'b0;
        drv1(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        drv2(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        #1;
        chk("t5_state_p", dut.state_q, PAIR);
        chk("t5_cnt20", dut.cnt_q[20], 5);
        chk("t5_stall", stall_cycles, 9);
        chk("t5_idle_pc", PC_enable, 1);

        // 6: WAW on r3 (cnt 6, new lat 2)
        nxt(); drv1(1, 0, 0, 0, 3'b000, 3, 1, 6, 0); #1;
        chk("t6_ld_issue1", issue1, 1);
        nxt(); drv1(1, 0, 0, 0, 3'b000, 3, 1, 2, 0); #1;
        chk("t6_cnt3", dut.cnt_q[3], 6);
        chk("t6_waw_a", issue1, 0);
        chk("t6_waw_pc", PC_enable, 0);
        for (int k = 0; k < 3; k++) begin
            nxt(); #1;
            chk("t6_waw_hold", issue1, 0);
        end
        nxt(); #1;
        chk("t6_waw_go", issue1, 1);
        chk("t6_stall", stall_cycles, 13);

        // r0 tracked normally; lat 0 behaves as 1
        nxt(); drv1(1, 0, 0, 0, 3'b000, 0, 1, 0, 0); #1;
        chk("t6_cnt3_ld", dut.cnt_q[3], 2);
        chk("r0_ld_issue1", issue1, 1);
        nxt(); drv1(1, 0, 0, 0, 3'b001, 0, 0, 1, 0); #1;
        chk("r0_cnt0", dut.cnt_q[0], 1);
        chk("r0_raw", issue1, 0);
        nxt(); #1;
        chk("r0_go", issue1, 1);
        chk("r0_stall", stall_cycles, 14);

        // slot 1 empty: pair rules off for slot 2
        nxt();
        drv1(0, 0, 0, 0, 3'b000, 40, 1, 1, 0);
        drv2(1, 0, 0, 0, 3'b000, 40, 1, 1, 0);
        #1;
        chk("solo2_issue1", issue1, 0);
        chk("solo2_issue2", issue2, 1);
        chk("solo2_pc", PC_enable, 1);

        // saturate: repeating pair RAW, 8 stalls per 9 cycles
        nxt();
        drv1(1, 0, 0, 0, 3'b000, 50, 1, 7, 0);
        drv2(1, 50, 0, 0, 3'b001, 0, 0, 1, 1);
        repeat (300) nxt();
        #1;
        chk("sat_stall", stall_cycles, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spu_issue_scoreboard.md
Name: spu_issue_scoreboard

Overview:
Dual-issue hazard and issue controller for the SPU pipeline. It sits in ID beside the decoder. Each cycle it decides whether Instruction1_ID and Instruction2_ID may enter ID_EX, using a per-register latency scoreboard and even/odd pipe pairing rules. It drives PC_enable so fetch holds while an instruction pair is not fully issued, and it counts stall cycles.

Parameters:
NUM_REGS, 128, number of architectural registers tracked
ADDR_W, 7, register address width
LAT_W, 3, latency field width; result latency range is 1..7 cycles
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  taken branch resolved in MEM (PC_Source_MEM)
i1_valid, i2_valid  in  1  slot holds a real instruction
i1_ra, i1_rb, i1_rc, i2_ra, i2_rb, i2_rc  in  ADDR_W  source register addresses
i1_use, i2_use  in  3  source-used flags {rc,rb,ra}
i1_rt, i2_rt  in  ADDR_W  destination register
i1_wr, i2_wr  in  1  instruction writes rt
i1_lat, i2_lat  in  LAT_W  result latency in cycles; 0 is treated as 1
i1_pipe, i2_pipe  in  1  execution pipe: 0 = even, 1 = odd
issue1, issue2  out  1  slot passes to ID_EX this cycle
PC_enable  out  1  fetch/IF_ID may advance
stall_cycles  out  CNT_W  saturating count of cycles with PC_enable = 0 outside reset

Behaviour:
- Scoreboard: one LAT_W down-counter per register, cnt[r].
  - Register r is ready when cnt[r] == 0.
  - Every cycle, each nonzero counter decrements by 1.
  - An issuing writer sets cnt[rt] to max(lat, 1). This load overrides the decrement.
  - If both slots issue with the same rt, that case is already blocked (see WAW_PAIR), so no conflict arises.
- Slot hazards, combinational on the current scoreboard:
  - RAW: a used source has cnt != 0.
  - WAW: wr = 1 and cnt[rt] > max(lat, 1).
- Pair rules for slot 2, in addition to its own hazards:
  - RAW_PAIR: i1_wr and a used i2 source equals i1_rt.
  - WAW_PAIR: i1_wr, i2_wr and i1_rt == i2_rt.
  - STRUCT: i1_pipe == i2_pipe.
  - Slot 2 issues only in the same cycle as slot 1 or after it (in order). It never issues before slot 1.
- FSM states: PAIR (reset state), SECOND.
  - PAIR:
    - issue1 = i1_valid & no slot-1 hazard.
    - issue2 = issue1 & i2_valid & no slot-2 hazard & no pair rule violated.
    - If i1_valid = 0, slot 2 is evaluated as if slot 1 had issued, with pair rules off.
    - PC_enable = 1 when every valid slot issues.
    - If slot 1 issues and slot 2 is valid but blocked, go to SECOND with PC_enable = 0.
  - SECOND:
    - issue1 = 0.
    - issue2 = i2_valid & no slot-2 hazard. Pair rules are off because slot 1's write is already on the scoreboard.
    - When slot 2 issues: PC_enable = 1, return to PAIR. Otherwise stay in SECOND with PC_enable = 0.
- flush (has priority over everything except reset):
  - issue1 = issue2 = 0, PC_enable = 1, next state PAIR.
  - Scoreboard keeps decrementing and is not cleared, because squashed writers are harmless but conservative.
- Reset cycle:
  - issue1 = issue2 = 0, PC_enable = 0.
  - All cnt cleared, state PAIR, stall_cycles = 0.
  - Outputs go to these values in the same cycle reset is high.
- Latency: issue decisions and PC_enable are combinational from the registered state, the scoreboard and ID inputs. Scoreboard and FSM update on the next rising edge.
- stall_cycles increments when PC_enable = 0 and reset = 0. It saturates at all-ones.
- Register 0 gets no special treatment; it is tracked like the others.

Decomposition:
- Package spu_pkg holds:
  - ADDR_W, LAT_W, NUM_REGS
  - typedef reg_addr_t
  - typedef issue_state_e {PAIR, SECOND}
  - typedef pipe_e {EVEN, ODD}
  - a slot_t struct grouping valid/ra/rb/rc/use/rt/wr/lat/pipe
- One sub-module, spu_sb_hazard, is combinational. It takes a slot_t and the scoreboard and returns raw/waw flags. It is instantiated twice.

Test Plan:
1. Reset held 2 cycles, then released with i1 = ILW (wr, rt = 5, lat = 2, pipe 0) and i2 invalid -> during reset issue1 = 0 and PC_enable = 0; first cycle after release issue1 = 1, PC_enable = 1; the next cycle cnt[5] = 2.
2. After case 1, i1 reads ra = 5 -> issue1 = 0 and PC_enable = 0 for exactly 2 cycles, then issue1 = 1; stall_cycles = 2.
3. Pair with i1 writes rt = 9 (pipe 0) and i2 reads rb = 9 (pipe 1) -> cycle 0: issue1 = 1, issue2 = 0, state SECOND; i2 issues once cnt[9] reaches 0 and PC_enable returns to 1.
4. Pair with both slots on pipe 1 and independent registers -> issue1 = 1, issue2 = 0, then issue2 = 1 the next cycle; exactly one stall cycle.
5. flush asserted while in SECOND with i2 blocked -> issue2 = 0, PC_enable = 1, state PAIR next cycle; scoreboard counters keep decrementing.
6. WAW check: rt = 3 pending with cnt = 6, new i1 writes rt = 3 with lat = 2 -> blocked until cnt[3] <= 2, then issues; 255 forced stalls with CNT_W = 8 -> stall_cycles saturates at 255.
